ps2_rx_event_fifo: RTL and testbench
====================================

Name: ps2_rx_event_fifo

Overview:
- Parametrised successor to the keyboard translator. Receives PS/2 device-to-host frames and checks start, odd parity and stop bits, with a frame watchdog.
- Decodes the E0 (extended) and F0 (break) prefixes into complete key events, optionally suppressing typematic repeats.
- Queues events in a FIFO with a valid/ready interface, consumed by the command/RTC control logic.

Parameters:
- FILTER_LEN, 8: number of consecutive equal ps2c samples required to accept a new clock level (2..16).
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, 2..16.
- TIMEOUT_CYC, 100000: Reloj cycles allowed between falling edges inside a frame before abort (1 ms at 100 MHz).
- REPORT_MAKE, 1: 1 = report make and break events; 0 = break events only.
- SUPPRESS_REPEAT, 1: 1 = drop a make event whose code and ext match the last make not yet released.

Ports:
- Reloj, input, 1: system clock, 100 MHz.
- RST, input, 1: reset; asynchronous, active-high.
- ps2c, input, 1: keyboard clock, asynchronous.
- DATA_IN, input, 1: keyboard serial data, asynchronous.
- evt_ready, input, 1: consumer accepts the head event this cycle.
- evt_valid, output, 1: FIFO not empty.
- evt_code, output, 8: scan code of the head event.
- evt_ext, output, 1: head event was E0-prefixed.
- evt_break, output, 1: head event is a release (F0-prefixed).
- fifo_count, output, $clog2(FIFO_DEPTH+1): number of entries held.
- parity_err, output, 1: one-cycle pulse, parity failure.
- frame_err, output, 1: one-cycle pulse, bad stop bit or timeout.
- overflow, output, 1: one-cycle pulse, event dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, RST=1):
  - Filter register set to all ones; filtered clock level set to 1, so no spurious edge occurs after reset.
  - Frame FSM to IDLE; prefix flags and last-make register cleared; FIFO emptied.
  - All outputs 0.
  - Reset during a frame discards the partial frame and all queued events.
- ps2c and DATA_IN pass through 2-flop synchronisers.
- Filter: shifts the synchronised ps2c each cycle. The level goes to 1 on all ones and to 0 on all zeros; otherwise it holds. fall = previous level 1 and new level 0.
- Frame FSM, advancing only on fall, DATA_IN sampled at fall:
  - IDLE: start bit 0 -> DATA with bit count 0. Start bit 1 -> stay in IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always returns to IDLE.
    - Stop bit 1 and (XOR of data and parity) = 1 -> byte_ok pulse.
    - Stop bit 1 and parity wrong -> parity_err pulse.
    - Stop bit 0 -> frame_err pulse, regardless of parity.
- Watchdog: counter cleared on every fall and held at 0 in IDLE. When it reaches TIMEOUT_CYC in any non-IDLE state: frame_err pulse, return to IDLE, byte discarded.
- Prefix decoder, acting on byte_ok:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte forms the event {ext, brk, code} and clears both flags.
  - Any parity_err or frame_err also clears both flags.
- Event filtering:
  - Make events are discarded when REPORT_MAKE=0.
  - With SUPPRESS_REPEAT=1, a make whose {ext, code} equals the last-make register is discarded. Any accepted make loads that register.
  - A break matching the register clears it; a break of another key leaves it unchanged.
- Latency: for the fall that ends STOP at cycle T, byte_ok and the error pulses are registered at T+1. The event is written at the end of T+1, and evt_valid and the head outputs are valid at T+2.
- FIFO:
  - Push on event when not full. If full and no pop in the same cycle, drop the event and pulse overflow.
  - Pop when evt_valid and evt_ready are both high.
  - Simultaneous push and pop: both happen, count unchanged, and full-with-pop accepts the push.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head outputs are stable while evt_valid=1 and evt_ready=0.
  - evt_ready while empty is ignored.
- Error and overflow pulses last exactly one cycle; pulses from independent events may coincide.

Test Plan:
1. Frame 0x1C (parity 0, stop 1), then F0 (parity 1), then 0x1C, with evt_ready=1 -> events {1C, ext0, brk0} then {1C, ext0, brk1}; no error pulses.
2. E0, 74 (parity 1), then E0, F0, 74 -> {74, ext1, brk0} then {74, ext1, brk1}.
3. SUPPRESS_REPEAT=1: 1C, 1C, 1C, F0, 1C -> exactly two events (make, break). With SUPPRESS_REPEAT=0 -> four events.
4. Frame 0x1C with parity 1 -> parity_err pulses once, no event. A following F0 (the flag was cleared), 1C -> single break event with brk1.
5. Send 3 bits, then ps2c held high for TIMEOUT_CYC+10 cycles -> one frame_err pulse, FSM back in IDLE. A subsequent valid 0x1C frame decodes correctly.
6. FIFO_DEPTH=4, evt_ready=0, send 5 distinct make codes -> fifo_count=4, one overflow pulse on the 5th. Then hold ready=1 -> the 4 codes drain in order and evt_valid falls after the 4th.

Source files
------------

// File: rtl/ps2_rx_event_fifo.sv
// ps2_rx_event_fifo: PS/2 frame receiver with E0/F0 prefix decoding, repeat filtering and an event FIFO
module ps2_rx_event_fifo #(
  parameter int FILTER_LEN      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYC     = 100000,
  parameter int REPORT_MAKE     = 1,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                            Reloj,
  input  logic                            RST,
  input  logic                            ps2c,
  input  logic                            DATA_IN,
  input  logic                            evt_ready,
  output logic                            evt_valid,
  output logic [7:0]                      evt_code,
  output logic                            evt_ext,
  output logic                            evt_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic RM = (REPORT_MAKE != 0);
  localparam logic SR = (SUPPRESS_REPEAT != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic                  r_c1, r_c2, r_d1, r_d2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_lvl, w_lvl_next, w_fall;
  state_t                r_state, w_state_next;
  logic [2:0]            r_bit_cnt, w_bit_cnt_next;
  logic [7:0]            r_shift, w_shift_next;
  logic                  r_par, w_par_next;
  logic [WW-1:0]         r_wd;
  logic                  w_timeout, w_byte_ok, w_perr, w_ferr;
  logic                  r_byte_ok, r_perr, r_ferr;
  logic                  r_ext, r_brk, r_lm_v;
  logic [8:0]            r_lm, w_key;
  logic                  w_is_e0, w_is_f0, w_evt, w_lm_hit, w_make_ok, w_push_req;
  logic [9:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_cnt;
  logic                  w_valid, w_full, w_push, w_pop, r_ovf;

  // two-flop synchronisers for the asynchronous keyboard lines; idle-high so reset gives no edge
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) {r_c1, r_c2, r_d1, r_d2} <= 4'b1111;
    else {r_c1, r_c2, r_d1, r_d2} <= {ps2c, r_c1, DATA_IN, r_d1};
  end

  // glitch filter: level only moves once the whole window agrees
  always_comb begin
    w_lvl_next = (&r_filt) ? 1'b1 : (~|r_filt) ? 1'b0 : r_lvl;
    w_fall     = r_lvl & ~w_lvl_next;
  end

  // filter shift register and accepted clock level
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_filt <= '1;
      r_lvl  <= 1'b1;
    end else begin
      r_filt <= {r_filt[FILTER_LEN-2:0], r_c2};
      r_lvl  <= w_lvl_next;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_wd == WW'(TIMEOUT_CYC));

  // frame FSM next state: advances on filtered falling edges; watchdog abort takes priority
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_byte_ok      = 1'b0;
    w_perr         = 1'b0;
    w_ferr         = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_ferr       = 1'b1;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE: begin
          w_state_next   = r_d2 ? S_IDLE : S_DATA;
          w_bit_cnt_next = 3'd0;
        end
        S_DATA: begin
          w_shift_next   = {r_d2, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          w_state_next   = (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          w_par_next   = r_d2;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          w_ferr       = ~r_d2;
          w_byte_ok    = r_d2 & (^{r_shift, r_par});
          w_perr       = r_d2 & ~(^{r_shift, r_par});
        end
      endcase
    end
  end

  // frame FSM registers, watchdog counter and registered frame status pulses
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      r_wd      <= '0;
      r_byte_ok <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_wd      <= (r_state == S_IDLE || w_fall) ? '0 : r_wd + WW'(1);
      r_byte_ok <= w_byte_ok;
      r_perr    <= w_perr;
      r_ferr    <= w_ferr;
    end
  end

  // event formation and filtering from the accepted byte (r_shift holds it until the next frame)
  always_comb begin
    w_is_e0    = (r_shift == 8'hE0);
    w_is_f0    = (r_shift == 8'hF0);
    w_evt      = r_byte_ok & ~w_is_e0 & ~w_is_f0;
    w_key      = {r_ext, r_shift};
    w_lm_hit   = r_lm_v && (r_lm == w_key);
    w_make_ok  = ~r_brk & ~(SR & w_lm_hit);
    w_push_req = w_evt & (r_brk | (RM & w_make_ok));
  end

  // prefix flags and last-make register
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_lm_v <= 1'b0;
      r_lm   <= 9'd0;
    end else begin
      if (r_perr | r_ferr) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_ok) begin
        r_ext <= w_is_e0 ? 1'b1 : w_is_f0 ? r_ext : 1'b0;
        r_brk <= w_is_f0 ? 1'b1 : w_is_e0 ? r_brk : 1'b0;
      end
      if (w_evt & w_make_ok) begin
        r_lm_v <= 1'b1;
        r_lm   <= w_key;
      end else if (w_evt & r_brk & w_lm_hit) r_lm_v <= 1'b0;
    end
  end

  assign w_valid = (r_cnt != '0);
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid & evt_ready;
  assign w_push  = w_push_req & (~w_full | w_pop);

  // event storage; contents need no reset since the pointers define what is held
  always_ff @(posedge Reloj) begin
    if (w_push) r_mem[r_wp] <= {r_ext, r_brk, r_shift};
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge Reloj or posedge RST) begin
    if (RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= (w_push & ~w_pop) ? r_cnt + CW'(1) : (~w_push & w_pop) ? r_cnt - CW'(1) : r_cnt;
      r_ovf <= w_push_req & w_full & ~w_pop;
    end
  end

  assign evt_valid                        = w_valid;
  assign {evt_ext, evt_break, evt_code}   = w_valid ? r_mem[r_rp] : 10'd0;
  assign fifo_count                       = r_cnt;
  assign parity_err                       = r_perr;
  assign frame_err                        = r_ferr;
  assign overflow                         = r_ovf;
endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// tb_ps2_rx_event_fifo: directed PS/2 frames against a frame-level event model, two repeat-filter settings
module tb_ps2_rx_event_fifo;
  localparam int FL = 4, DEPTH = 4, TMO = 300;

  logic clk = 1'b0, rst = 1'b1, ps2c = 1'b1, data = 1'b1, ready = 1'b0;
  logic va, vb, xa, xb, ba, bb, pa, pb, fa, fb, oa, ob;
  logic [7:0] ca, cb;
  logic [2:0] na, nb;

  always #5 clk = ~clk;

  ps2_rx_event_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO),
                      .REPORT_MAKE(1), .SUPPRESS_REPEAT(1)) u_a (
    .Reloj(clk), .RST(rst), .ps2c(ps2c), .DATA_IN(data), .evt_ready(ready),
    .evt_valid(va), .evt_code(ca), .evt_ext(xa), .evt_break(ba), .fifo_count(na),
    .parity_err(pa), .frame_err(fa), .overflow(oa));

  ps2_rx_event_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO),
                      .REPORT_MAKE(1), .SUPPRESS_REPEAT(0)) u_b (
    .Reloj(clk), .RST(rst), .ps2c(ps2c), .DATA_IN(data), .evt_ready(ready),
    .evt_valid(vb), .evt_code(cb), .evt_ext(xb), .evt_break(bb), .fifo_count(nb),
    .parity_err(pb), .frame_err(fb), .overflow(ob));

  int n_checks = 0, n_errors = 0, quiet = 0;
  logic       m_ext [2], m_brk [2], m_lmv [2];
  logic [8:0] m_lm [2];
  logic [9:0] mq [2][$];
  logic [9:0] plog [2][$];
  int         m_perr [2], m_ferr [2], m_ovf [2], n_perr [2], n_ferr [2], n_ovf [2];
  logic [2:0] prev [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_push(input int d, input logic [9:0] e);
    if (mq[d].size() == DEPTH) m_ovf[d]++;
    else mq[d].push_back(e);
  endtask

  // one complete frame as seen by the consumer; d=0 suppresses repeats, d=1 does not
  task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
    for (int d = 0; d < 2; d++) begin
      logic [8:0] key;
      key = {m_ext[d], b};
      if (!s) begin
        m_ferr[d]++; m_ext[d] = 0; m_brk[d] = 0;
      end else if ($countones({b, p}) % 2 == 0) begin
        m_perr[d]++; m_ext[d] = 0; m_brk[d] = 0;
      end else if (b == 8'hE0) m_ext[d] = 1;
      else if (b == 8'hF0) m_brk[d] = 1;
      else begin
        if (m_brk[d]) begin
          if (m_lmv[d] && m_lm[d] == key) m_lmv[d] = 0;
          m_push(d, {m_ext[d], 1'b1, b});
        end else if (!(d == 0 && m_lmv[d] && m_lm[d] == key)) begin
          m_lmv[d] = 1; m_lm[d] = key;
          m_push(d, {m_ext[d], 1'b0, b});
        end
        m_ext[d] = 0; m_brk[d] = 0;
      end
    end
  endtask

  task automatic model_abort();
    for (int d = 0; d < 2; d++) begin
      m_ferr[d]++; m_ext[d] = 0; m_brk[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete(); m_ext[d] = 0; m_brk[d] = 0; m_lmv[d] = 0;
    end
  endtask

  task automatic cmp(input int d, input logic v, input logic [2:0] n, input logic [9:0] h,
                     input logic pe, input logic fe, input logic ov);
    if (pe) n_perr[d]++;
    if (fe) n_ferr[d]++;
    if (ov) n_ovf[d]++;
    if (pe | fe | ov) chk($sformatf("pulse_width%0d", d), {pe, fe, ov} & prev[d], 3'b000);
    prev[d] = {pe, fe, ov};
    if (quiet >= 12) begin
      chk($sformatf("valid%0d", d), v, mq[d].size() != 0);
      chk($sformatf("count%0d", d), n, mq[d].size());
      if (v && mq[d].size() != 0) chk($sformatf("head%0d", d), h, mq[d][0]);
    end
    if (v && ready) begin
      chk($sformatf("pop_expected%0d", d), v, mq[d].size() != 0);
      if (mq[d].size() != 0) begin
        chk($sformatf("pop_head%0d", d), h, mq[d][0]);
        void'(mq[d].pop_front());
      end
      plog[d].push_back(h);
    end
  endtask

  always @(negedge clk) begin
    quiet = ps2c ? quiet + 1 : 0;
    if (!rst) begin
      cmp(0, va, na, {xa, ba, ca}, pa, fa, oa);
      cmp(1, vb, nb, {xb, bb, cb}, pb, fb, ob);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic x);
    data = x; tick(5);
    ps2c = 0; tick(20);
    ps2c = 1; tick(15);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic s);
    logic p;
    p = ~(^b) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    data = s; tick(5);
    model_frame(b, p, s);
    ps2c = 0; tick(20);
    ps2c = 1; tick(15);
  endtask

  task automatic check_counts();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("perr_count%0d", d), n_perr[d], m_perr[d]);
      chk($sformatf("ferr_count%0d", d), n_ferr[d], m_ferr[d]);
      chk($sformatf("ovf_count%0d", d), n_ovf[d], m_ovf[d]);
    end
  endtask

  task automatic clear_logs();
    plog[0].delete(); plog[1].delete();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ext[d] = 0; m_brk[d] = 0; m_lmv[d] = 0; m_lm[d] = 0; prev[d] = 0;
      m_perr[d] = 0; m_ferr[d] = 0; m_ovf[d] = 0; n_perr[d] = 0; n_ferr[d] = 0; n_ovf[d] = 0;
    end
    tick(3);
    chk("reset_valid", va, 1'b0);
    chk("reset_count", na, 3'd0);
    chk("reset_pulses", {pa, fa, oa, pb, fb, ob}, 6'd0);
    rst = 0; tick(20);
    ready = 1;
    // 1: make then break of 1C
    send_frame(8'h1C, 0, 1); send_frame(8'hF0, 0, 1); send_frame(8'h1C, 0, 1); tick(10);
    chk("t1_len", plog[0].size(), 2);
    if (plog[0].size() == 2) begin
      chk("t1_ev0", plog[0][0], 10'h01C);
      chk("t1_ev1", plog[0][1], 10'h11C);
    end
    check_counts(); clear_logs();
    // 2: extended make and break of 74
    send_frame(8'hE0, 0, 1); send_frame(8'h74, 0, 1);
    send_frame(8'hE0, 0, 1); send_frame(8'hF0, 0, 1); send_frame(8'h74, 0, 1); tick(10);
    chk("t2_len", plog[0].size(), 2);
    if (plog[0].size() == 2) begin
      chk("t2_ev0", plog[0][0], 10'h274);
      chk("t2_ev1", plog[0][1], 10'h374);
    end
    check_counts(); clear_logs();
    // 3: typematic repeats
    send_frame(8'h1C, 0, 1); send_frame(8'h1C, 0, 1); send_frame(8'h1C, 0, 1);
    send_frame(8'hF0, 0, 1); send_frame(8'h1C, 0, 1); tick(10);
    chk("t3_len_sup", plog[0].size(), 2);
    chk("t3_len_nosup", plog[1].size(), 4);
    check_counts(); clear_logs();
    // 4: parity error clears nothing pending, then a clean break
    send_frame(8'h1C, 1, 1); tick(5);
    chk("t4_perr", n_perr[0], 1);
    chk("t4_noevt", plog[0].size(), 0);
    send_frame(8'hF0, 0, 1); send_frame(8'h1C, 0, 1); tick(10);
    chk("t4_len", plog[0].size(), 1);
    if (plog[0].size() == 1) chk("t4_ev0", plog[0][0], 10'h11C);
    check_counts(); clear_logs();
    // 5: watchdog abort mid-frame, then recovery
    send_bit(0); send_bit(1); send_bit(0);
    model_abort();
    tick(TMO + 10);
    chk("t5_ferr", n_ferr[0], 1);
    send_frame(8'h1C, 0, 1); tick(10);
    chk("t5_len", plog[0].size(), 1);
    if (plog[0].size() == 1) chk("t5_ev0", plog[0][0], 10'h01C);
    check_counts(); clear_logs();
    // 6: fill, overflow, drain in order
    ready = 0;
    send_frame(8'h15, 0, 1); send_frame(8'h1D, 0, 1); send_frame(8'h24, 0, 1);
    send_frame(8'h2D, 0, 1); send_frame(8'h2C, 0, 1); tick(10);
    chk("t6_count_a", na, 3'd4);
    chk("t6_count_b", nb, 3'd4);
    chk("t6_ovf_a", n_ovf[0], 1);
    check_counts();
    ready = 1; tick(10);
    chk("t6_len", plog[0].size(), 4);
    if (plog[0].size() == 4) begin
      chk("t6_ev0", plog[0][0], 10'h015);
      chk("t6_ev1", plog[0][1], 10'h01D);
      chk("t6_ev2", plog[0][2], 10'h024);
      chk("t6_ev3", plog[0][3], 10'h02D);
    end
    chk("t6_empty", va, 1'b0);
    clear_logs();
    // 7: reset mid-frame discards queued event and partial frame
    ready = 0;
    send_frame(8'h33, 0, 1);
    send_bit(0); send_bit(1);
    rst = 1; model_reset(); tick(3);
    chk("t7_rst_valid", va, 1'b0);
    chk("t7_rst_count", na, 3'd0);
    rst = 0; tick(10);
    send_frame(8'h1C, 0, 1); tick(10);
    ready = 1; tick(5);
    chk("t7_len", plog[0].size(), 1);
    if (plog[0].size() == 1) chk("t7_ev0", plog[0][0], 10'h01C);
    check_counts();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
